// File: rtl/calc_sequencer_if.sv
// Keypad-strobe, ALU handshake and display bundle for the calculator sequencer.
// The sequencer connects through the slave modport; keypad/ALU side uses master.
interface calc_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             dig_strobe;
    logic             reset_strobe;
    logic             ex_strobe;
    logic             op_strobe;
    logic             sub_strobe;
    logic [3:0]       dig_code;
    logic [1:0]       op_code;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_op;
    logic             alu_start;
    logic             alu_done;
    logic [WIDTH-1:0] alu_result;
    logic             alu_err;
    logic [WIDTH-1:0] disp_value;
    logic             err;
    logic [2:0]       state;

    modport master (
        output dig_strobe, reset_strobe, ex_strobe, op_strobe, sub_strobe,
        output dig_code, op_code, alu_done, alu_result, alu_err,
        input  alu_a, alu_b, alu_op, alu_start, disp_value, err, state
    );

    modport slave (
        input  dig_strobe, reset_strobe, ex_strobe, op_strobe, sub_strobe,
        input  dig_code, op_code, alu_done, alu_result, alu_err,
        output alu_a, alu_b, alu_op, alu_start, disp_value, err, state
    );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator control FSM: decimal operand entry, operator latch, one ALU
// operation at a time over start/done, and the value shown on the display.
module calc_sequencer #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4
) (
    input logic            clk,
    input logic            rst_n,
    calc_sequencer_if.slave bus
);

    localparam int unsigned       CW   = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0]     MAXC = CW'(MAX_DIGITS);
    localparam logic [WIDTH-1:0]  TEN  = WIDTH'(10);

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        ENTER_B = 3'd1,
        EXEC    = 3'd2,
        RESULT  = 3'd3,
        ERROR   = 3'd4,
        ABORT   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, mag_q, mag_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, disp_q, disp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic             start_q, start_d, err_q, err_d;

    logic             clr_key, dig, op, ex, done, clr, cur_neg;
    logic             dig_ok, lead_minus, op_take, op_replace, ex_go;
    logic [WIDTH-1:0] dig_ext, acc, acc_s;

    // reset_strobe outranks every key; digit outranks operator, operator outranks execute
    assign clr_key    = bus.reset_strobe;
    assign dig        = bus.dig_strobe & ~clr_key;
    assign op         = bus.op_strobe & ~bus.dig_strobe & ~clr_key;
    assign ex         = bus.ex_strobe & ~bus.dig_strobe & ~bus.op_strobe & ~clr_key;
    assign done       = bus.alu_done;

    assign dig_ext    = {{(WIDTH-4){1'b0}}, bus.dig_code};
    assign acc        = mag_q * TEN + dig_ext;
    assign cur_neg    = (state_q == ENTER_B) ? neg_b_q : neg_a_q;
    assign acc_s      = cur_neg ? -acc : acc;

    assign dig_ok     = dig & (cnt_q < MAXC);
    assign lead_minus = op & bus.sub_strobe & (cnt_q == '0);
    assign op_take    = op & (cnt_q != '0);
    assign op_replace = op & ~bus.sub_strobe & (cnt_q == '0);
    assign ex_go      = ex & (cnt_q != '0);

    // A clear key that lands on the same cycle as alu_done needs no abort wait
    assign clr = (clr_key && state_q != EXEC && state_q != ABORT)
              || ((state_q == ABORT || (state_q == EXEC && clr_key)) && done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            mag_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            alu_a_q <= '0;
            alu_b_q <= '0;
            start_q <= 1'b0;
            disp_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mag_q   <= mag_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
            start_q <= start_d;
            disp_q  <= disp_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ENTER_A;
        end else begin
            unique case (state_q)
                ENTER_A: if (op_take) state_d = ENTER_B;
                ENTER_B: if (ex_go) state_d = EXEC;
                EXEC: begin
                    if (clr_key)   state_d = ABORT;
                    else if (done) state_d = bus.alu_err ? ERROR : RESULT;
                end
                RESULT: begin
                    if (dig)     state_d = ENTER_A;
                    else if (op) state_d = ENTER_B;
                    else if (ex) state_d = EXEC;
                end
                ERROR:   state_d = ERROR;
                ABORT:   state_d = ABORT;
                default: state_d = ENTER_A;
            endcase
        end
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        mag_d   = mag_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        alu_a_d = alu_a_q;
        alu_b_d = alu_b_q;
        start_d = 1'b0;
        disp_d  = disp_q;
        err_d   = err_q;
        unique case (state_q)
            ENTER_A: begin
                if (dig_ok) begin
                    mag_d  = acc;
                    cnt_d  = cnt_q + 1'b1;
                    a_d    = acc_s;
                    disp_d = acc_s;
                end else if (lead_minus) begin
                    neg_a_d = ~neg_a_q;
                end else if (op_take) begin
                    op_d    = bus.op_code;
                    mag_d   = '0;
                    cnt_d   = '0;
                    neg_b_d = 1'b0;
                    b_d     = '0;
                end
            end
            ENTER_B: begin
                if (dig_ok) begin
                    mag_d  = acc;
                    cnt_d  = cnt_q + 1'b1;
                    b_d    = acc_s;
                    disp_d = acc_s;
                end else if (lead_minus) begin
                    neg_b_d = ~neg_b_q;
                end else if (op_replace) begin
                    op_d = bus.op_code;
                end else if (ex_go) begin
                    alu_a_d = a_q;
                    alu_b_d = b_q;
                    start_d = 1'b1;
                end
            end
            EXEC: begin
                if (!clr_key && done) begin
                    if (bus.alu_err) begin
                        err_d  = 1'b1;
                        disp_d = '0;
                    end else begin
                        disp_d = bus.alu_result;
                        a_d    = bus.alu_result;
                    end
                end
            end
            RESULT: begin
                // A keeps the result so operator/execute chain from it; B is kept for repeat
                if (dig) begin
                    mag_d   = dig_ext;
                    cnt_d   = CW'(1);
                    neg_a_d = 1'b0;
                    a_d     = dig_ext;
                    disp_d  = dig_ext;
                end else if (op) begin
                    op_d    = bus.op_code;
                    mag_d   = '0;
                    cnt_d   = '0;
                    neg_b_d = 1'b0;
                    b_d     = '0;
                end else if (ex) begin
                    alu_a_d = a_q;
                    alu_b_d = b_q;
                    start_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (clr) begin
            a_d     = '0;
            b_d     = '0;
            mag_d   = '0;
            cnt_d   = '0;
            op_d    = '0;
            neg_a_d = 1'b0;
            neg_b_d = 1'b0;
            alu_a_d = '0;
            alu_b_d = '0;
            start_d = 1'b0;
            disp_d  = '0;
            err_d   = 1'b0;
        end
    end

    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = op_q;
    assign bus.alu_start  = start_q;
    assign bus.disp_value = disp_q;
    assign bus.err        = err_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed test of calc_sequencer: key sequences with hand-computed results,
// a scripted ALU that answers with fixed latency.
module tb_calc_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   extra_starts;

    calc_sequencer_if #(.WIDTH(16)) bus ();

    calc_sequencer #(.WIDTH(16), .MAX_DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic key_digit(input logic [3:0] d);
        @(negedge clk);
        bus.dig_code   = d;
        bus.dig_strobe = 1'b1;
        @(negedge clk);
        bus.dig_strobe = 1'b0;
    endtask

    task automatic key_op(input logic [1:0] c, input logic s);
        @(negedge clk);
        bus.op_code    = c;
        bus.sub_strobe = s;
        bus.op_strobe  = 1'b1;
        @(negedge clk);
        bus.op_strobe  = 1'b0;
        bus.sub_strobe = 1'b0;
    endtask

    task automatic key_ex();
        @(negedge clk);
        bus.ex_strobe = 1'b1;
        @(negedge clk);
        bus.ex_strobe = 1'b0;
    endtask

    task automatic key_clr();
        @(negedge clk);
        bus.reset_strobe = 1'b1;
        @(negedge clk);
        bus.reset_strobe = 1'b0;
    endtask

    // Scripted ALU: counts any alu_start seen while busy, then pulses done
    task automatic alu_reply(input int lat, input logic [15:0] res, input logic e);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            if (bus.alu_start === 1'b1) extra_starts++;
        end
        bus.alu_result = res;
        bus.alu_err    = e;
        bus.alu_done   = 1'b1;
        @(negedge clk);
        bus.alu_done   = 1'b0;
        bus.alu_err    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
        checks++; if (bus.disp_value !== 16'd0) begin failures++; $display("FAIL reset_disp got=%0d exp=0", bus.disp_value); end
        checks++; if (bus.err !== 1'b0 || bus.alu_start !== 1'b0) begin failures++; $display("FAIL reset_flags got err=%b start=%b exp=0,0", bus.err, bus.alu_start); end
        checks++; if (bus.alu_a !== 16'd0 || bus.alu_b !== 16'd0 || bus.alu_op !== 2'd0) begin failures++; $display("FAIL reset_alu got a=%0d b=%0d op=%0d exp=0", bus.alu_a, bus.alu_b, bus.alu_op); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        key_clr();
        key_digit(4'd1);
        key_digit(4'd2);
        checks++; if (bus.disp_value !== 16'd12) begin failures++; $display("FAIL add_entry_a got=%0d exp=12", bus.disp_value); end
        key_op(2'd0, 1'b0);
        checks++; if (bus.state !== 3'd1 || bus.disp_value !== 16'd12) begin failures++; $display("FAIL add_op got state=%0d disp=%0d exp=1,12", bus.state, bus.disp_value); end
        key_digit(4'd3);
        key_digit(4'd4);
        checks++; if (bus.disp_value !== 16'd34) begin failures++; $display("FAIL add_entry_b got=%0d exp=34", bus.disp_value); end
        key_ex();
        checks++; if (bus.alu_start !== 1'b1 || bus.state !== 3'd2) begin failures++; $display("FAIL add_start got start=%b state=%0d exp=1,2", bus.alu_start, bus.state); end
        checks++; if (bus.alu_a !== 16'd12 || bus.alu_b !== 16'd34 || bus.alu_op !== 2'd0) begin failures++; $display("FAIL add_operands got a=%0d b=%0d op=%0d exp=12,34,0", bus.alu_a, bus.alu_b, bus.alu_op); end
        extra_starts = 0;
        alu_reply(3, 16'd46, 1'b0);
        checks++; if (extra_starts !== 0) begin failures++; $display("FAIL add_single_start got extra=%0d exp=0", extra_starts); end
        checks++; if (bus.disp_value !== 16'd46 || bus.state !== 3'd3) begin failures++; $display("FAIL add_result got disp=%0d state=%0d exp=46,3", bus.disp_value, bus.state); end
    endtask

    task automatic test_signed();
        key_clr();
        key_op(2'd1, 1'b1);
        checks++; if (bus.state !== 3'd0) begin failures++; $display("FAIL sign_lead_a got state=%0d exp=0", bus.state); end
        key_digit(4'd5);
        checks++; if (bus.disp_value !== 16'hFFFB) begin failures++; $display("FAIL sign_disp_a got=%h exp=fffb", bus.disp_value); end
        key_op(2'd2, 1'b0);
        key_op(2'd1, 1'b1);
        checks++; if (bus.state !== 3'd1 || bus.alu_op !== 2'd2) begin failures++; $display("FAIL sign_lead_b got state=%0d op=%0d exp=1,2", bus.state, bus.alu_op); end
        key_digit(4'd3);
        checks++; if (bus.disp_value !== 16'hFFFD) begin failures++; $display("FAIL sign_disp_b got=%h exp=fffd", bus.disp_value); end
        key_ex();
        checks++; if (bus.alu_a !== 16'hFFFB || bus.alu_b !== 16'hFFFD || bus.alu_op !== 2'd2) begin failures++; $display("FAIL sign_operands got a=%h b=%h op=%0d exp=fffb,fffd,2", bus.alu_a, bus.alu_b, bus.alu_op); end
        alu_reply(2, 16'd15, 1'b0);
        checks++; if (bus.disp_value !== 16'd15) begin failures++; $display("FAIL sign_result got=%0d exp=15", bus.disp_value); end
    endtask

    task automatic test_max_digits();
        key_clr();
        for (int d = 1; d <= 6; d++) key_digit(4'(d));
        checks++; if (bus.disp_value !== 16'd1234 || bus.state !== 3'd0) begin failures++; $display("FAIL maxdig got disp=%0d state=%0d exp=1234,0", bus.disp_value, bus.state); end
    endtask

    task automatic test_error();
        key_clr();
        key_digit(4'd8);
        key_op(2'd3, 1'b0);
        key_digit(4'd0);
        key_ex();
        checks++; if (bus.alu_a !== 16'd8 || bus.alu_b !== 16'd0 || bus.alu_op !== 2'd3) begin failures++; $display("FAIL err_operands got a=%0d b=%0d op=%0d exp=8,0,3", bus.alu_a, bus.alu_b, bus.alu_op); end
        alu_reply(1, 16'd0, 1'b1);
        checks++; if (bus.err !== 1'b1 || bus.state !== 3'd4 || bus.disp_value !== 16'd0) begin failures++; $display("FAIL err_enter got err=%b state=%0d disp=%0d exp=1,4,0", bus.err, bus.state, bus.disp_value); end
        key_digit(4'd5);
        key_ex();
        checks++; if (bus.err !== 1'b1 || bus.state !== 3'd4 || bus.disp_value !== 16'd0 || bus.alu_start !== 1'b0) begin failures++; $display("FAIL err_hold got err=%b state=%0d disp=%0d start=%b exp=1,4,0,0", bus.err, bus.state, bus.disp_value, bus.alu_start); end
        key_clr();
        checks++; if (bus.err !== 1'b0 || bus.state !== 3'd0 || bus.disp_value !== 16'd0) begin failures++; $display("FAIL err_clear got err=%b state=%0d disp=%0d exp=0,0,0", bus.err, bus.state, bus.disp_value); end
    endtask

    task automatic test_repeat();
        key_clr();
        key_digit(4'd7);
        key_op(2'd0, 1'b0);
        key_digit(4'd2);
        key_ex();
        alu_reply(1, 16'd9, 1'b0);
        checks++; if (bus.disp_value !== 16'd9) begin failures++; $display("FAIL rep_first got=%0d exp=9", bus.disp_value); end
        key_ex();
        checks++; if (bus.alu_start !== 1'b1 || bus.alu_a !== 16'd9 || bus.alu_b !== 16'd2 || bus.alu_op !== 2'd0) begin failures++; $display("FAIL rep_second got start=%b a=%0d b=%0d op=%0d exp=1,9,2,0", bus.alu_start, bus.alu_a, bus.alu_b, bus.alu_op); end
        alu_reply(1, 16'd11, 1'b0);
        key_ex();
        checks++; if (bus.alu_a !== 16'd11 || bus.alu_b !== 16'd2) begin failures++; $display("FAIL rep_third got a=%0d b=%0d exp=11,2", bus.alu_a, bus.alu_b); end
        alu_reply(1, 16'd13, 1'b0);
        checks++; if (bus.disp_value !== 16'd13 || bus.state !== 3'd3) begin failures++; $display("FAIL rep_result got disp=%0d state=%0d exp=13,3", bus.disp_value, bus.state); end
    endtask

    task automatic test_back_to_back();
        key_clr();
        key_op(2'd0, 1'b0);
        key_ex();
        checks++; if (bus.state !== 3'd0 || bus.alu_start !== 1'b0) begin failures++; $display("FAIL b2b_ignore_a got state=%0d start=%b exp=0,0", bus.state, bus.alu_start); end
        key_digit(4'd5);
        key_op(2'd0, 1'b0);
        key_ex();
        checks++; if (bus.state !== 3'd1 || bus.alu_start !== 1'b0) begin failures++; $display("FAIL b2b_ignore_b got state=%0d start=%b exp=1,0", bus.state, bus.alu_start); end
        key_op(2'd2, 1'b0);
        key_digit(4'd6);
        key_ex();
        checks++; if (bus.alu_a !== 16'd5 || bus.alu_b !== 16'd6 || bus.alu_op !== 2'd2) begin failures++; $display("FAIL b2b_replace got a=%0d b=%0d op=%0d exp=5,6,2", bus.alu_a, bus.alu_b, bus.alu_op); end
        alu_reply(1, 16'd30, 1'b0);
        key_op(2'd1, 1'b1);
        checks++; if (bus.state !== 3'd1 || bus.disp_value !== 16'd30 || bus.alu_op !== 2'd1) begin failures++; $display("FAIL b2b_chain_op got state=%0d disp=%0d op=%0d exp=1,30,1", bus.state, bus.disp_value, bus.alu_op); end
        key_digit(4'd4);
        key_ex();
        checks++; if (bus.alu_a !== 16'd30 || bus.alu_b !== 16'd4) begin failures++; $display("FAIL b2b_chain_ex got a=%0d b=%0d exp=30,4", bus.alu_a, bus.alu_b); end
        alu_reply(1, 16'd26, 1'b0);
        key_digit(4'd9);
        checks++; if (bus.state !== 3'd0 || bus.disp_value !== 16'd9) begin failures++; $display("FAIL b2b_new_a got state=%0d disp=%0d exp=0,9", bus.state, bus.disp_value); end
        @(negedge clk);
        bus.dig_code   = 4'd1;
        bus.op_code    = 2'd0;
        bus.dig_strobe = 1'b1;
        bus.op_strobe  = 1'b1;
        @(negedge clk);
        bus.dig_strobe = 1'b0;
        bus.op_strobe  = 1'b0;
        checks++; if (bus.state !== 3'd0 || bus.disp_value !== 16'd91) begin failures++; $display("FAIL b2b_dig_wins got state=%0d disp=%0d exp=0,91", bus.state, bus.disp_value); end
    endtask

    task automatic test_abort();
        key_clr();
        key_digit(4'd3);
        key_op(2'd0, 1'b0);
        key_digit(4'd4);
        key_ex();
        key_clr();
        checks++; if (bus.state !== 3'd5) begin failures++; $display("FAIL abort_enter got state=%0d exp=5", bus.state); end
        extra_starts = 0;
        alu_reply(4, 16'd7, 1'b0);
        checks++; if (extra_starts !== 0) begin failures++; $display("FAIL abort_no_start got extra=%0d exp=0", extra_starts); end
        checks++; if (bus.state !== 3'd0 || bus.disp_value !== 16'd0 || bus.alu_a !== 16'd0) begin failures++; $display("FAIL abort_exit got state=%0d disp=%0d a=%0d exp=0,0,0", bus.state, bus.disp_value, bus.alu_a); end
        alu_reply(1, 16'd99, 1'b0);
        checks++; if (bus.state !== 3'd0 || bus.disp_value !== 16'd0) begin failures++; $display("FAIL stray_done got state=%0d disp=%0d exp=0,0", bus.state, bus.disp_value); end
    endtask

    task automatic test_async_reset();
        key_digit(4'd1);
        key_op(2'd0, 1'b0);
        key_digit(4'd1);
        key_ex();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.state !== 3'd0 || bus.alu_start !== 1'b0 || bus.alu_a !== 16'd0) begin failures++; $display("FAIL async_reset got state=%0d start=%b a=%0d exp=0,0,0", bus.state, bus.alu_start, bus.alu_a); end
        @(negedge clk);
        rst_n = 1'b1;
        alu_reply(2, 16'd42, 1'b0);
        checks++; if (bus.state !== 3'd0 || bus.disp_value !== 16'd0) begin failures++; $display("FAIL async_late_done got state=%0d disp=%0d exp=0,0", bus.state, bus.disp_value); end
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        extra_starts     = 0;
        rst_n            = 1'b0;
        bus.dig_strobe   = 1'b0;
        bus.reset_strobe = 1'b0;
        bus.ex_strobe    = 1'b0;
        bus.op_strobe    = 1'b0;
        bus.sub_strobe   = 1'b0;
        bus.dig_code     = 4'd0;
        bus.op_code      = 2'd0;
        bus.alu_done     = 1'b0;
        bus.alu_result   = 16'd0;
        bus.alu_err      = 1'b0;
        test_reset();
        test_add();
        test_signed();
        test_max_digits();
        test_error();
        test_repeat();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
